// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  typedef enum logic {
    SEL_UNITS = 1'b0,
    SEL_TENS  = 1'b1
  } sel_e;

  // Active-low segments, index 0 = a ... index 6 = g
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;

endpackage

// File: rtl/dec_bcd_7seg.sv
// Decimal digit to active-low seven-segment decoder; codes above 9 blank the digit.
module dec_bcd_7seg
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/controle_display.sv
// Two-digit display sequencer: accepts a 6-bit value, splits it into tens/units by
// repeated subtraction, and scans both digits onto one segment bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module controle_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_num,
  output logic       busy,
  output logic [0:6] seg,
  output logic [1:0] an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [5:0]       rem_q, rem_d;
  logic [2:0]       acc_q, acc_d;
  logic [2:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_e             sel_q, sel_d;
  logic [3:0]       digit_mux;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    tens_d     = tens_q;
    units_d    = units_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          rem_d      = in_num;
          acc_d      = '0;
          state_d    = CONV;
          in_ready_d = 1'b0;
        end
      end
      CONV: begin
        if (rem_q >= 6'd10) begin
          rem_d = rem_q - 6'd10;
          acc_d = acc_q + 3'd1;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Both digits change on the same edge so the scan never shows a mixed pair
        tens_d     = acc_q;
        units_d    = rem_q[3:0];
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = (sel_q == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      rem_q      <= '0;
      acc_q      <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      cnt_q      <= '0;
      sel_q      <= SEL_UNITS;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
    end
  end

  always_comb begin
    if (sel_q == SEL_TENS) begin
      an        = 2'b01;
      digit_mux = {1'b0, tens_q};
`ifdef LEADING_ZERO_BLANK_EN
      // A non-decimal code makes the single shared decoder emit a blank
      if (tens_q == '0) digit_mux = 4'hF;
`endif
    end else begin
      an        = 2'b10;
      digit_mux = units_q;
    end
  end

  dec_bcd_7seg u_dec (
    .digit (digit_mux),
    .seg   (seg)
  );

  assign in_ready = in_ready_q;
  assign busy     = ~in_ready_q;

endmodule

// File: tb/tb_controle_display.sv
// Self-checking bench for controle_display with REFRESH_DIV=4.
module tb_controle_display;

  localparam int unsigned DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [0:6] TZ = 7'b1111111;
`else
  localparam logic [0:6] TZ = 7'b0000001;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_num = '0;
  logic       in_ready;
  logic       busy;
  logic [0:6] seg;
  logic [1:0] an;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         num;
    int         lat;
    logic [0:6] su;
    logic [0:6] st;
  } vec_t;

  vec_t vecs[8];

  controle_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_num   (in_num),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  function automatic logic [0:6] ref_seg(input int d);
    logic [0:6] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return (d >= 0 && d < 10) ? tbl[d] : 7'b1111111;
  endfunction

  function automatic logic [0:6] ref_tens_seg(input int t);
    return (t == 0) ? TZ : ref_seg(t);
  endfunction

  // Waits (bounded) for in_ready at a falling edge, then presents n for one transfer.
  task automatic offer(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, " ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    in_num   = 6'(n);
    @(negedge clk);
  endtask

  task automatic count_busy(input int exp_lat, input int start, input string tag);
    int cnt = start;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, cnt, exp_lat);
  endtask

  task automatic send(input int n, input int exp_lat, input string tag);
    offer(n, tag);
    in_valid = 1'b0;
    count_busy(exp_lat, 0, tag);
  endtask

  task automatic check_display(input logic [0:6] eu, input logic [0:6] et, input string tag);
    logic [0:6] su = 'x;
    logic [0:6] st = 'x;
    int bad_an = 0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      @(negedge clk);
      if (an == 2'b10) su = seg;
      else if (an == 2'b01) st = seg;
      else bad_an++;
    end
    chk({tag, " units_seg"}, su, eu);
    chk({tag, " tens_seg"}, st, et);
    chk({tag, " an_legal"}, bad_an, 0);
  endtask

  initial begin
    vecs[0] = '{37, 5, 7'b0001111, 7'b0000110};
    vecs[1] = '{0,  2, 7'b0000001, TZ};
    vecs[2] = '{63, 8, 7'b0000110, 7'b0100000};
    vecs[3] = '{9,  2, 7'b0000100, TZ};
    vecs[4] = '{10, 3, 7'b0000001, 7'b1001111};
    vecs[5] = '{45, 6, 7'b0100100, 7'b1001100};
    vecs[6] = '{19, 3, 7'b0000100, 7'b1001111};
    vecs[7] = '{50, 7, 7'b0000001, 7'b0100100};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst an", an, 2'b10);
    chk("rst seg", seg, 7'b0000001);
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].num, vecs[i].lat, $sformatf("vec%0d", vecs[i].num));
      check_display(vecs[i].su, vecs[i].st, $sformatf("vec%0d", vecs[i].num));
    end

    // 12 held on in_valid throughout the 63 conversion
    offer(63, "hold63");
    in_num = 6'd12;
    count_busy(8, 0, "hold63");
    chk("hold63 ready", in_ready, 1);
    chk("hold63 seg", seg, (an == 2'b10) ? ref_seg(3) : ref_tens_seg(6));
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold12 accepted", busy, 1);
    count_busy(3, 0, "hold12");
    check_display(ref_seg(2), ref_tens_seg(1), "hold12");

    // Randomized values against arithmetic reference
    for (int i = 0; i < 24; i++) begin
      int n = int'($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(n, n / 10 + 2, $sformatf("rnd%0d", n));
      check_display(ref_seg(n % 10), ref_tens_seg(n / 10), $sformatf("rnd%0d", n));
    end

    // Reset during the second CONV cycle of 59
    send(41, 6, "pre41");
    offer(59, "abort59");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort an", an, 2'b10);
    chk("abort seg", seg, 7'b0000001);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan from a fresh counter
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan%0d an", i), an, ((i / DIV) % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    check_display(ref_seg(0), ref_tens_seg(0), "after_abort");
    chk("after_abort idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
